// File: rtl/bsg_cam_nr1w_tag_array_alloc.sv
// rtl/bsg_cam_nr1w_tag_array_alloc.sv - multi-port CAM valid/tag array with victim allocation and flush engine
module bsg_cam_nr1w_tag_array_alloc #(
    parameter int width_p      = 8,
    parameter int els_p        = 4,
    parameter int read_ports_p = 2,
    localparam int lg_els_lp   = $clog2(els_p),
    localparam int lg_cnt_lp   = $clog2(els_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              w_v_i,
    input  logic [1:0]                        w_op_i,
    input  logic [width_p-1:0]                w_tag_i,
    input  logic [lg_els_lp-1:0]              w_idx_i,
    output logic                              w_ready_o,
    output logic [lg_els_lp-1:0]              alloc_idx_o,
    output logic                              alloc_replace_o,
    input  logic [read_ports_p-1:0]           r_v_i,
    input  logic [read_ports_p*width_p-1:0]   r_tag_i,
    output logic [read_ports_p*els_p-1:0]     r_match_o,
    output logic [read_ports_p-1:0]           r_hit_o,
    output logic [els_p-1:0]                  empty_o,
    output logic                              full_o,
    output logic [lg_cnt_lp-1:0]              count_o,
    output logic                              evict_v_o,
    output logic [width_p-1:0]                evict_tag_o,
    output logic [lg_els_lp-1:0]              evict_idx_o,
    input  logic                              evict_yumi_i,
    output logic                              flush_done_o
);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [els_p-1:0]       v_q, v_d;
    logic [width_p-1:0]     tag_q [els_p];
    logic [lg_els_lp-1:0]   rr_q, rr_d, fptr_q, fptr_d;

    logic                   w_hit, any_empty;
    logic [lg_els_lp-1:0]   w_hit_idx, empty_idx;
    logic                   tag_we;
    logic [lg_els_lp-1:0]   tag_widx;
    logic                   fptr_last, flush_adv;

    always_comb begin
        r_match_o = '0;
        r_hit_o   = '0;
        for (int p = 0; p < read_ports_p; p++) begin
            for (int i = 0; i < els_p; i++) begin
                r_match_o[p*els_p+i] = r_v_i[p] & v_q[i] & (tag_q[i] == r_tag_i[p*width_p +: width_p]);
                r_hit_o[p]           = r_hit_o[p] | r_match_o[p*els_p+i];
            end
        end
    end

    // Descending scan so the lowest matching / empty index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        any_empty = 1'b0;
        empty_idx = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (v_q[i] && (tag_q[i] == w_tag_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = lg_els_lp'(i);
            end
            if (!v_q[i]) begin
                any_empty = 1'b1;
                empty_idx = lg_els_lp'(i);
            end
        end
    end

    assign alloc_idx_o     = w_hit ? w_hit_idx : (any_empty ? empty_idx : rr_q);
    assign alloc_replace_o = ~w_hit & ~any_empty;

    always_comb begin
        count_o = '0;
        for (int i = 0; i < els_p; i++) begin
            count_o = count_o + lg_cnt_lp'(v_q[i]);
        end
    end

    assign empty_o   = ~v_q;
    assign full_o    = &v_q;
    assign w_ready_o = (state_q == IDLE);

    assign fptr_last   = (fptr_q == lg_els_lp'(els_p - 1));
    assign evict_v_o   = (state_q == FLUSH) & v_q[fptr_q];
    assign evict_tag_o = tag_q[fptr_q];
    assign evict_idx_o = fptr_q;
    assign flush_adv   = (state_q == FLUSH) & (~v_q[fptr_q] | evict_yumi_i);

    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        rr_d         = rr_q;
        fptr_d       = fptr_q;
        tag_we       = 1'b0;
        tag_widx     = '0;
        flush_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_v_i) begin
                    case (w_op_i)
                        2'd0: begin
                            if (!w_hit) begin
                                v_d[alloc_idx_o] = 1'b1;
                                tag_we           = 1'b1;
                                tag_widx         = alloc_idx_o;
                                if (alloc_replace_o) begin
                                    rr_d = (rr_q == lg_els_lp'(els_p - 1)) ? '0 : rr_q + 1'b1;
                                end
                            end
                        end
                        2'd1: begin
                            if (w_hit) v_d[w_hit_idx] = 1'b0;
                        end
                        2'd2: begin
                            v_d[w_idx_i] = 1'b1;
                            tag_we       = 1'b1;
                            tag_widx     = w_idx_i;
                        end
                        default: begin
                            state_d = FLUSH;
                            fptr_d  = '0;
                        end
                    endcase
                end
            end
            default: begin
                if (flush_adv) begin
                    v_d[fptr_q] = 1'b0;
                    if (fptr_last) begin
                        state_d      = IDLE;
                        fptr_d       = '0;
                        rr_d         = '0;
                        flush_done_o = 1'b1;
                    end else begin
                        fptr_d = fptr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            v_q     <= '0;
            rr_q    <= '0;
            fptr_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            rr_q    <= rr_d;
            fptr_q  <= fptr_d;
        end
    end

    // Tag storage is qualified by v_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (tag_we) tag_q[tag_widx] <= w_tag_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            for (int p = 0; p < read_ports_p; p++) begin
                assert ($countones(r_match_o[p*els_p +: els_p]) <= 1);
            end
            assert (!evict_yumi_i || evict_v_o);
            assert (!w_v_i || w_ready_o);
            assert (!(w_v_i && w_op_i == 2'd2) || (int'(w_idx_i) < els_p));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cam_nr1w_tag_array_alloc.sv
// tb/tb_bsg_cam_nr1w_tag_array_alloc.sv - scoreboard bench for bsg_cam_nr1w_tag_array_alloc
module tb_bsg_cam_nr1w_tag_array_alloc;

    localparam int W = 8;
    localparam int E = 4;
    localparam int P = 2;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic            w_v_i;
    logic [1:0]      w_op_i;
    logic [W-1:0]    w_tag_i;
    logic [1:0]      w_idx_i;
    logic            w_ready_o;
    logic [1:0]      alloc_idx_o;
    logic            alloc_replace_o;
    logic [P-1:0]    r_v_i;
    logic [P*W-1:0]  r_tag_i;
    logic [P*E-1:0]  r_match_o;
    logic [P-1:0]    r_hit_o;
    logic [E-1:0]    empty_o;
    logic            full_o;
    logic [2:0]      count_o;
    logic            evict_v_o;
    logic [W-1:0]    evict_tag_o;
    logic [1:0]      evict_idx_o;
    logic            evict_yumi_i;
    logic            flush_done_o;

    always #5 clk = ~clk;

    bsg_cam_nr1w_tag_array_alloc #(.width_p(W), .els_p(E), .read_ports_p(P)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .w_v_i(w_v_i), .w_op_i(w_op_i), .w_tag_i(w_tag_i), .w_idx_i(w_idx_i),
        .w_ready_o(w_ready_o), .alloc_idx_o(alloc_idx_o), .alloc_replace_o(alloc_replace_o),
        .r_v_i(r_v_i), .r_tag_i(r_tag_i), .r_match_o(r_match_o), .r_hit_o(r_hit_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
        .evict_v_o(evict_v_o), .evict_tag_o(evict_tag_o), .evict_idx_o(evict_idx_o),
        .evict_yumi_i(evict_yumi_i), .flush_done_o(flush_done_o)
    );

    typedef struct packed {
        logic [P*E-1:0] match;
        logic [P-1:0]   hit;
        logic [E-1:0]   empty;
        logic           full;
        logic [2:0]     count;
        logic           ready;
        logic           ev_v;
        logic [W-1:0]   ev_tag;
        logic [1:0]     ev_idx;
        logic           done;
        logic           chk_alloc;
        logic [1:0]     a_idx;
        logic           a_rep;
    } exp_t;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] tag;
    } ev_t;

    exp_t expq[$];
    ev_t  evq[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit           mv   [E];
    logic [W-1:0] mtag [E];
    int           mrr, mfptr;
    bit           mflush;
    int           ydelay = -1;
    int           wait_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        ev_t  x;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("r_match", 32'(r_match_o), 32'(e.match));
            chk("r_hit", 32'(r_hit_o), 32'(e.hit));
            chk("empty", 32'(empty_o), 32'(e.empty));
            chk("full", 32'(full_o), 32'(e.full));
            chk("count", 32'(count_o), 32'(e.count));
            chk("w_ready", 32'(w_ready_o), 32'(e.ready));
            chk("evict_v", 32'(evict_v_o), 32'(e.ev_v));
            chk("flush_done", 32'(flush_done_o), 32'(e.done));
            if (e.ev_v) begin
                chk("evict_tag", 32'(evict_tag_o), 32'(e.ev_tag));
                chk("evict_idx", 32'(evict_idx_o), 32'(e.ev_idx));
            end
            if (e.chk_alloc) begin
                chk("alloc_idx", 32'(alloc_idx_o), 32'(e.a_idx));
                chk("alloc_replace", 32'(alloc_replace_o), 32'(e.a_rep));
            end
        end
        if (reset_n_i && evict_v_o && evict_yumi_i) begin
            if (evq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL evict_order: got idx %0d expected no eviction", evict_idx_o);
            end else begin
                x = evq.pop_front();
                chk("evict_seq_idx", 32'(evict_idx_o), 32'(x.idx));
                chk("evict_seq_tag", 32'(evict_tag_o), 32'(x.tag));
            end
        end
    end

    function automatic logic [W-1:0] pick();
        return 8'h10 + 8'($urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < E; i++) mv[i] = 1'b0;
        mrr = 0; mfptr = 0; mflush = 1'b0; wait_cnt = 0;
        evq.delete();
    endtask

    task automatic cycle(input bit cv, input logic [1:0] op, input logic [W-1:0] tag, input logic [1:0] idx,
                         input bit rd_rnd, input logic [P-1:0] rv, input logic [P*W-1:0] rt);
        exp_t e;
        ev_t  ev;
        int   hit, emp, cnt;
        bit   pres, y, adv;
        @(posedge clk);
        #1;
        if (rd_rnd) begin
            rv = 2'($urandom_range(0, 3));
            rt = {pick(), pick()};
        end
        r_v_i = rv;
        r_tag_i = rt;
        e = '0;
        cnt = 0;
        for (int i = 0; i < E; i++) begin
            for (int p = 0; p < P; p++) begin
                e.match[p*E+i] = rv[p] && mv[i] && (mtag[i] == rt[p*W +: W]);
                if (e.match[p*E+i]) e.hit[p] = 1'b1;
            end
            e.empty[i] = !mv[i];
            cnt += int'(mv[i]);
        end
        e.full  = (cnt == E);
        e.count = 3'(cnt);
        e.ready = !mflush;
        if (mflush) begin
            w_v_i = 1'b0;
            pres = mv[mfptr];
            y = 1'b0;
            if (pres) y = (ydelay < 0) ? ($urandom_range(0, 2) == 0) : (wait_cnt >= ydelay);
            evict_yumi_i = y;
            e.ev_v   = pres;
            e.ev_tag = mtag[mfptr];
            e.ev_idx = 2'(mfptr);
            adv = !pres || y;
            e.done = adv && (mfptr == E - 1);
            expq.push_back(e);
            wait_cnt = (pres && !y) ? wait_cnt + 1 : 0;
            if (adv) begin
                mv[mfptr] = 1'b0;
                if (mfptr == E - 1) begin
                    mflush = 1'b0; mfptr = 0; mrr = 0;
                end else begin
                    mfptr++;
                end
            end
        end else begin
            evict_yumi_i = 1'b0;
            if (cv && op == 2'd2)
                for (int i = 0; i < E; i++) if (i != int'(idx) && mv[i] && mtag[i] == tag) cv = 1'b0;
            w_v_i = cv; w_op_i = op; w_tag_i = tag; w_idx_i = idx;
            if (cv) begin
                case (op)
                    2'd0: begin
                        hit = -1; emp = -1;
                        for (int i = E - 1; i >= 0; i--) begin
                            if (mv[i] && mtag[i] == tag) hit = i;
                            if (!mv[i]) emp = i;
                        end
                        e.chk_alloc = 1'b1;
                        if (hit >= 0) begin
                            e.a_idx = 2'(hit);
                        end else if (emp >= 0) begin
                            e.a_idx = 2'(emp); mv[emp] = 1'b1; mtag[emp] = tag;
                        end else begin
                            e.a_idx = 2'(mrr); e.a_rep = 1'b1; mtag[mrr] = tag; mrr = (mrr + 1) % E;
                        end
                    end
                    2'd1: for (int i = 0; i < E; i++) if (mv[i] && mtag[i] == tag) mv[i] = 1'b0;
                    2'd2: begin mtag[idx] = tag; mv[idx] = 1'b1; end
                    default: begin
                        mflush = 1'b1; mfptr = 0; wait_cnt = 0;
                        for (int i = 0; i < E; i++) if (mv[i]) begin
                            ev.idx = 2'(i); ev.tag = mtag[i]; evq.push_back(ev);
                        end
                    end
                endcase
            end
            expq.push_back(e);
        end
    endtask

    task automatic run_flush();
        cycle(1'b1, 2'd3, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);
        for (int k = 0; k < 200 && mflush; k++) cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);
        if (mflush) begin
            vectors++; miscompares++;
            $display("FAIL flush_timeout: got still flushing expected done");
        end
    endtask

    task automatic op_c(input logic [1:0] op, input logic [W-1:0] tag, input logic [1:0] idx);
        cycle(1'b1, op, tag, idx, 1'b1, 2'b00, 16'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n_i = 1'b0; w_v_i = 1'b0; w_op_i = 2'd0; w_tag_i = '0; w_idx_i = '0;
        r_v_i = '0; r_tag_i = '0; evict_yumi_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 reset_n_i = 1'b1;

        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 2'b00, 16'h0);
        op_c(2'd0, 8'h11, 2'd0); op_c(2'd0, 8'h22, 2'd0);
        op_c(2'd0, 8'h33, 2'd0); op_c(2'd0, 8'h44, 2'd0);
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 2'b00, 16'h0);
        op_c(2'd0, 8'h55, 2'd0); op_c(2'd0, 8'h66, 2'd0); op_c(2'd0, 8'h77, 2'd0);
        op_c(2'd0, 8'h88, 2'd0); op_c(2'd0, 8'h99, 2'd0);
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 2'b01, 16'h0011);
        op_c(2'd0, 8'h66, 2'd0);
        op_c(2'd1, 8'h66, 2'd0);
        op_c(2'd0, 8'hAB, 2'd0);
        cycle(1'b1, 2'd2, 8'h5A, 2'd2, 1'b0, 2'b11, 16'h8877);
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 2'b11, 16'h8877);

        op_c(2'd1, 8'hAB, 2'd0);
        op_c(2'd1, 8'h88, 2'd0);
        ydelay = 3;
        run_flush();
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);
        ydelay = -1;

        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 99);
            op = (r < 45) ? 2'd0 : (r < 72) ? 2'd1 : (r < 96) ? 2'd2 : 2'd3;
            cycle($urandom_range(0, 4) != 0, op, pick(), 2'($urandom_range(0, 3)), 1'b1, 2'b00, 16'h0);
        end
        for (int k = 0; k < 200 && mflush; k++) cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);

        ydelay = 1000;
        op_c(2'd2, 8'hC3, 2'd0);
        cycle(1'b1, 2'd3, 8'h00, 2'd0, 1'b0, 2'b00, 16'h0);
        @(posedge clk);
        #1 w_v_i = 1'b0; evict_yumi_i = 1'b0;
        #1 chk("pre_reset_evict_v", 32'(evict_v_o), 32'd1);
        reset_n_i = 1'b0;
        #1;
        chk("rst_evict_v", 32'(evict_v_o), 32'd0);
        chk("rst_w_ready", 32'(w_ready_o), 32'd1);
        chk("rst_empty", 32'(empty_o), 32'hF);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_flush_done", 32'(flush_done_o), 32'd0);
        @(posedge clk);
        #1 chk("rst_hold_flush_done", 32'(flush_done_o), 32'd0);
        #2 reset_n_i = 1'b1;
        model_reset();
        ydelay = -1;
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);
        op_c(2'd0, 8'h12, 2'd0);
        op_c(2'd0, 8'h13, 2'd0);
        cycle(1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 2'b00, 16'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        chk("evict_queue_drained", 32'(evq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
